// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module   : ir_carrier_gen
// Purpose  : Multi-channel IR carrier generator with fractional phase
//            accumulators, selectable duty and drain-to-period-end on gate drop.
// Revision : 1.0 - initial release
// ============================================================================
module ir_carrier_gen #(
    parameter int FCLK         = 50_000_000,
    parameter int NUM_CH       = 2,
    parameter int FREQ_W       = 20,
    parameter int DEFAULT_FREQ = 38_000,
    parameter int DEFAULT_DUTY = 2,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] gate,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [1:0]        cfg_duty,
    output logic [NUM_CH-1:0] carrier,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] period_tick
);

    localparam int ACC_W = $clog2(FCLK) + 1;
    localparam int CMP_W = (FREQ_W > ACC_W) ? FREQ_W : ACC_W;

    localparam logic [ACC_W:0]   C_FCLK     = (ACC_W+1)'(FCLK);
    localparam logic [ACC_W-1:0] C_HALF     = ACC_W'(FCLK / 2);
    localparam logic [CMP_W-1:0] C_HALF_CMP = CMP_W'(FCLK / 2);
    localparam logic [ACC_W-1:0] C_Q1       = ACC_W'(FCLK / 4);
    localparam logic [ACC_W-1:0] C_Q2       = ACC_W'(2 * (FCLK / 4));
    localparam logic [ACC_W-1:0] C_Q3       = ACC_W'(3 * (FCLK / 4));
    localparam logic [ACC_W-1:0] C_DEF_FREQ = ACC_W'(DEFAULT_FREQ);
    localparam logic [1:0]       C_DEF_DUTY = 2'(DEFAULT_DUTY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [NUM_CH-1:0] w_idle;
    logic [CMP_W-1:0]  w_cfg_wide;
    logic [ACC_W-1:0]  w_cfg_freq;

    // Out-of-range channel numbers match no channel, so ready stays high and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = w_idle[i];
            end
        end
    end

    assign w_cfg_wide = CMP_W'(cfg_freq);
    assign w_cfg_freq = (w_cfg_wide > C_HALF_CMP) ? C_HALF : w_cfg_wide[ACC_W-1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nx;
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] w_acc_nx;
        logic [ACC_W-1:0] r_freq;
        logic [1:0]       r_duty;
        logic             r_carrier;
        logic             w_carrier_nx;
        logic             r_tick;
        logic             w_tick_nx;
        logic             r_busy;
        logic [ACC_W:0]   w_sum;
        logic             w_wrap;
        logic [ACC_W-1:0] w_step;
        logic [ACC_W-1:0] w_thresh;
        logic             w_cfg_we;

        assign w_idle[i]      = (r_state == S_IDLE);
        assign w_cfg_we       = cfg_valid && (cfg_ch == CH_W'(i)) && (r_state == S_IDLE);
        assign carrier[i]     = r_carrier;
        assign busy[i]        = r_busy;
        assign period_tick[i] = r_tick;

        always_comb begin
            w_sum  = {1'b0, r_acc} + {1'b0, r_freq};
            w_wrap = (w_sum >= C_FCLK);
            w_step = w_wrap ? ACC_W'(w_sum - C_FCLK) : w_sum[ACC_W-1:0];
            case (r_duty)
                2'd1:    w_thresh = C_Q1;
                2'd2:    w_thresh = C_Q2;
                2'd3:    w_thresh = C_Q3;
                default: w_thresh = '0;
            endcase
        end

        always_comb begin
            w_state_nx   = r_state;
            w_acc_nx     = r_acc;
            w_carrier_nx = r_carrier;
            w_tick_nx    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_acc_nx     = '0;
                    w_carrier_nx = 1'b0;
                    if (gate[i] && (r_freq != '0)) begin
                        w_state_nx   = S_RUN;
                        w_carrier_nx = (r_duty != 2'd0);
                    end
                end
                S_RUN, S_DRAIN: begin
                    // Re-asserting gate while draining keeps the phase running.
                    w_acc_nx     = w_step;
                    w_carrier_nx = (w_step < w_thresh);
                    w_tick_nx    = w_wrap;
                    if (gate[i]) begin
                        w_state_nx = S_RUN;
                    end else if (w_wrap) begin
                        w_state_nx   = S_IDLE;
                        w_acc_nx     = '0;
                        w_carrier_nx = 1'b0;
                    end else begin
                        w_state_nx = S_DRAIN;
                    end
                end
                default: begin
                    w_state_nx   = S_IDLE;
                    w_acc_nx     = '0;
                    w_carrier_nx = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_state   <= S_IDLE;
                r_acc     <= '0;
                r_freq    <= C_DEF_FREQ;
                r_duty    <= C_DEF_DUTY;
                r_carrier <= 1'b0;
                r_tick    <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_acc     <= w_acc_nx;
                r_carrier <= w_carrier_nx;
                r_tick    <= w_tick_nx;
                r_busy    <= (w_state_nx != S_IDLE);
                if (w_cfg_we) begin
                    r_freq <= w_cfg_freq;
                    r_duty <= cfg_duty;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_carrier_gen
// Purpose  : Directed self-checking bench for ir_carrier_gen at FCLK = 1 MHz.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_carrier_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  gate;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [19:0] cfg_freq;
    logic [1:0]  cfg_duty;
    logic [1:0]  carrier;
    logic [1:0]  busy;
    logic [1:0]  period_tick;

    int n_cmp = 0;
    int n_bad = 0;

    ir_carrier_gen #(
        .FCLK(1_000_000), .NUM_CH(2), .FREQ_W(20),
        .DEFAULT_FREQ(38_000), .DEFAULT_DUTY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .gate(gate),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_freq(cfg_freq), .cfg_duty(cfg_duty),
        .carrier(carrier), .busy(busy), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic ch, input int freq, input logic [1:0] duty);
        int waited = 0;
        cfg_ch    = ch;
        cfg_freq  = 20'(freq);
        cfg_duty  = duty;
        cfg_valid = 1'b1;
        while (!cfg_ready && waited < 50) begin
            step();
            waited++;
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_timeout ch%0d: ready=%b required 1", ch, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; gate = 2'b00; cfg_valid = 1'b0;
        cfg_ch = 1'b0; cfg_freq = '0; cfg_duty = 2'd0;
        step(); step();
        n_cmp++; if (carrier !== 2'b00) begin n_bad++; $display("FAIL reset_carrier: got %b required 00", carrier); end
        n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b required 00", busy); end
        n_cmp++; if (period_tick !== 2'b00) begin n_bad++; $display("FAIL reset_tick: got %b required 00", period_tick); end
        reset_n = 1'b1;
        step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
    endtask

    task automatic test_basic();
        configure(1'b0, 250_000, 2'd2);
        gate[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++; if (carrier[0] !== ((c % 4) < 2)) begin n_bad++; $display("FAIL basic_carrier c=%0d: got %b required %b", c, carrier[0], (c % 4) < 2); end
            n_cmp++; if (period_tick[0] !== (c > 0 && (c % 4) == 0)) begin n_bad++; $display("FAIL basic_tick c=%0d: got %b", c, period_tick[0]); end
            n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy c=%0d: got %b required 1", c, busy[0]); end
        end
        gate[0] = 1'b0;
        step();
        n_cmp++; if ({busy[0], carrier[0], period_tick[0]} !== 3'b001) begin
            n_bad++; $display("FAIL basic_end busy/carrier/tick: got %b required 001", {busy[0], carrier[0], period_tick[0]});
        end
        step();
    endtask

    task automatic test_no_drift();
        int ticks = 0;
        int highs = 0;
        configure(1'b0, 300_000, 2'd2);
        gate[0] = 1'b1;
        for (int c = 0; c < 10_000; c++) begin
            step();
            ticks += int'(period_tick[0]);
            highs += int'(carrier[0]);
        end
        gate[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            ticks += int'(period_tick[0]);
            highs += int'(carrier[0]);
            if (!busy[0]) break;
        end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL drift_drain_end: busy=%b required 0", busy[0]); end
        n_cmp++; if (ticks != 3000) begin n_bad++; $display("FAIL drift_ticks: got %0d required 3000", ticks); end
        n_cmp++; if (highs < 4998 || highs > 5002) begin n_bad++; $display("FAIL drift_highs: got %0d required 5000+-2", highs); end
        step();
    endtask

    task automatic test_drain();
        logic [4:0] exp_car  = 5'b00001;
        logic [4:0] exp_busy = 5'b01111;
        logic [4:0] exp_tick = 5'b10000;
        configure(1'b0, 250_000, 2'd1);
        for (int c = 0; c < 5; c++) begin
            gate[0] = (c == 0);
            step();
            n_cmp++; if (carrier[0] !== exp_car[c]) begin n_bad++; $display("FAIL drain_carrier c=%0d: got %b required %b", c, carrier[0], exp_car[c]); end
            n_cmp++; if (busy[0] !== exp_busy[c]) begin n_bad++; $display("FAIL drain_busy c=%0d: got %b required %b", c, busy[0], exp_busy[c]); end
            n_cmp++; if (period_tick[0] !== exp_tick[c]) begin n_bad++; $display("FAIL drain_tick c=%0d: got %b required %b", c, period_tick[0], exp_tick[c]); end
        end
        gate[0] = 1'b0;
        step();
    endtask

    task automatic test_reassert();
        configure(1'b0, 250_000, 2'd2);
        for (int c = 0; c <= 12; c++) begin
            gate[0] = (c < 2) || (c >= 3 && c < 12);
            step();
            n_cmp++; if (carrier[0] !== ((c < 12) && ((c % 4) < 2))) begin n_bad++; $display("FAIL reassert_carrier c=%0d: got %b", c, carrier[0]); end
            n_cmp++; if (period_tick[0] !== (c > 0 && (c % 4) == 0)) begin n_bad++; $display("FAIL reassert_tick c=%0d: got %b", c, period_tick[0]); end
            n_cmp++; if (busy[0] !== (c < 12)) begin n_bad++; $display("FAIL reassert_busy c=%0d: got %b", c, busy[0]); end
        end
        step();
    endtask

    task automatic test_independent();
        configure(1'b1, 250_000, 2'd2);
        for (int c = 0; c <= 14; c++) begin
            int d = c - 2;
            gate[0] = (c < 12);
            gate[1] = (c >= 2 && c < 14);
            step();
            n_cmp++; if (carrier[0] !== ((c < 12) && ((c % 4) < 2))) begin n_bad++; $display("FAIL indep_ch0_carrier c=%0d: got %b", c, carrier[0]); end
            n_cmp++; if (busy[0] !== (c < 12)) begin n_bad++; $display("FAIL indep_ch0_busy c=%0d: got %b", c, busy[0]); end
            n_cmp++; if (carrier[1] !== ((d >= 0) && (d < 12) && ((d % 4) < 2))) begin n_bad++; $display("FAIL indep_ch1_carrier c=%0d: got %b", c, carrier[1]); end
            n_cmp++; if (busy[1] !== ((d >= 0) && (d < 12))) begin n_bad++; $display("FAIL indep_ch1_busy c=%0d: got %b", c, busy[1]); end
            n_cmp++; if (period_tick[1] !== (d > 0 && (d % 4) == 0)) begin n_bad++; $display("FAIL indep_ch1_tick c=%0d: got %b", c, period_tick[1]); end
        end
        gate = 2'b00;
        step();
    endtask

    task automatic test_config();
        int waited = 0;
        configure(1'b0, 250_000, 2'd2);
        gate[0] = 1'b1;
        step();
        gate[0] = 1'b0;
        cfg_ch = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_other_ch: got %b required 1", cfg_ready); end
        cfg_ch = 1'b0; cfg_freq = 20'd900_000; cfg_duty = 2'd2; cfg_valid = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_ready_busy: got %b required 0", cfg_ready); end
        while (!cfg_ready && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++; if (waited != 4) begin n_bad++; $display("FAIL cfg_wait_cycles: got %0d required 4", waited); end
        step();
        cfg_valid = 1'b0;
        gate[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++; if (carrier[0] !== ((c % 2) == 0)) begin n_bad++; $display("FAIL clamp_carrier c=%0d: got %b", c, carrier[0]); end
            n_cmp++; if (period_tick[0] !== (c > 0 && (c % 2) == 0)) begin n_bad++; $display("FAIL clamp_tick c=%0d: got %b", c, period_tick[0]); end
        end
        gate[0] = 1'b0;
        step();
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL clamp_end_busy: got %b required 0", busy[0]); end
        configure(1'b0, 0, 2'd2);
        gate[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if ({busy[0], carrier[0]} !== 2'b00) begin n_bad++; $display("FAIL zero_freq c=%0d: busy/carrier=%b required 00", c, {busy[0], carrier[0]}); end
        end
        gate[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        configure(1'b0, 250_000, 2'd2);
        gate[0] = 1'b1;
        step(); step(); step();
        reset_n = 1'b0;
        step();
        n_cmp++; if (carrier[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_carrier: got %b required 0", carrier[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b required 0", busy[0]); end
        reset_n = 1'b1;
        // Default 38 kHz at 1 MHz: high while 38000*n < 500000 (n<=13), wrap at n=27.
        for (int c = 0; c <= 27; c++) begin
            step();
            n_cmp++; if (carrier[0] !== (c <= 13 || c == 27)) begin n_bad++; $display("FAIL rstmid_default_carrier c=%0d: got %b", c, carrier[0]); end
            n_cmp++; if (period_tick[0] !== (c == 27)) begin n_bad++; $display("FAIL rstmid_default_tick c=%0d: got %b", c, period_tick[0]); end
        end
        gate[0] = 1'b0;
    endtask

    initial begin
        gate = 2'b00;
        test_reset();
        test_basic();
        test_no_drift();
        test_drain();
        test_reassert();
        test_independent();
        test_config();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_carrier_gen.md
Name: ir_carrier_gen

Overview:
- Multi-channel IR carrier generator for IR transmit bursts (NEC and similar protocols).
- Each channel has a fractional phase accumulator, so average frequency is exact with no remainder loss.
- Duty cycle is selectable per channel. Output is phase-aligned to gate assertion, and the current period always completes when the gate drops.
- Sits between the protocol encoder (drives `gate`) and the IR LED drivers. Frequency and duty are runtime-programmable through a valid/ready config port.

Parameters:
- FCLK, 50_000_000, clk frequency in Hz.
- NUM_CH, 2, number of independent carrier channels (1..8).
- FREQ_W, 20, width of the frequency word in Hz.
- DEFAULT_FREQ, 38_000, per-channel carrier frequency after reset, in Hz.
- DEFAULT_DUTY, 2, per-channel duty code after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- gate  input  NUM_CH  per-channel burst enable (from encoder).
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept; combinational = (state[cfg_ch]==IDLE).
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel.
- cfg_freq  input  FREQ_W  carrier frequency in Hz.
- cfg_duty  input  2  0=off, 1=25%, 2=50%, 3=75%.
- carrier  output  NUM_CH  registered carrier outputs.
- busy  output  NUM_CH  channel in RUN or DRAIN.
- period_tick  output  NUM_CH  1-cycle pulse on accumulator wrap.

Behaviour:
- Reset (reset_n low at posedge clk), all channels:
  - state=IDLE, acc=0, freq=DEFAULT_FREQ, duty=DEFAULT_DUTY.
  - carrier=0, busy=0, period_tick=0.
  - Reset mid-burst aborts immediately, with no drain.
- Config:
  - Write occurs on a cycle with cfg_valid & cfg_ready. It updates freq/duty of cfg_ch, effective the next cycle.
  - cfg_ch ≥ NUM_CH: cfg_ready=1, write is dropped.
  - cfg_freq==0 is stored; the channel never leaves IDLE while freq==0.
  - cfg_freq > FCLK/2 is clamped to FCLK/2.
- Thresholds: thresh = duty*(FCLK/4), computed with integer FCLK/4. ACC_W = $clog2(FCLK)+1.
- Accumulator step (RUN/DRAIN, every cycle):
  - sum = acc+freq.
  - If sum ≥ FCLK: acc ← sum−FCLK, wrap=1.
  - Else: acc ← sum, wrap=0.
- FSM per channel (IDLE, RUN, DRAIN):
  - IDLE, gate=1, freq≠0 → RUN; acc←0; carrier←(duty≠0).
  - IDLE otherwise: carrier=0, acc=0.
  - RUN, gate=1: step accumulator; carrier ← (acc_next < thresh).
  - RUN, gate=0: step accumulator; → DRAIN, or directly → IDLE if wrap occurs that same cycle.
  - DRAIN, gate=0: step; on wrap → IDLE, carrier←0, acc←0.
  - DRAIN, gate=1: → RUN with no phase reset (re-assert mid-drain continues the same carrier).
- Outputs:
  - period_tick = wrap, registered alongside carrier.
  - busy = (state≠IDLE), registered.
- Latency: gate rising sampled at edge k → carrier=1 and busy=1 after edge k. The first high phase starts at acc=0.
- Simultaneity:
  - Config cannot coincide with activity on the same channel (ready low).
  - Channels are fully independent.
  - Gate toggling at 1-cycle pulses in IDLE gives a minimum of one full carrier period.
- duty=0 in RUN: carrier stays 0, but the FSM, period_tick and busy operate normally.

Test Plan:
- FCLK=1_000_000, freq=250_000, duty=2, gate high 40 cycles → carrier pattern 1,1,0,0 repeating from the cycle after gate. period_tick every 4 cycles, starting cycle 4.
- freq=300_000, duty=2, gate high 10_000 cycles → exactly 3000 period_tick pulses (no drift). Carrier high count 5000±2.
- freq=250_000, duty=1; gate drops 1 cycle into a period → carrier completes the period (1,0,0,0). busy falls on the wrap cycle. No truncated pulse.
- Gate re-asserted during DRAIN → no phase restart; tick spacing stays 4 cycles. Independently, gate asserted on ch1 mid-burst of ch0 → ch1 starts at acc=0 with ch0 unaffected.
- cfg_valid to ch0 while ch0 busy → cfg_ready=0 until IDLE, then accepted. cfg_freq=900_000 is clamped to 500_000, giving 1,0 toggling. cfg_freq=0 → gate ignored, busy stays 0.
- reset_n low mid-burst → next cycle carrier=0, busy=0, freq reverts to DEFAULT_FREQ.
